// File: rtl/rom_arbiter.sv
// Round-robin sequencer sharing one registered-output ROM among NUM_REQ requesters.
// Latency: req -> grant/ROM read +1, rsp_valid +3; one read in flight, req ignored while busy.
module rom_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic                          rsp_valid,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [WIDTH-1:0]              rsp_data,
   output logic                          rom_chip_sel,
   output logic                          rom_read_ena,
   output logic [ADDR_WIDTH-1:0]         rom_address,
   input  logic [WIDTH-1:0]              rom_data_in
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t                state, state_nxt;
   // Last winner; it also serves as the ID of the transaction in flight.
   logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
   logic [NUM_REQ-1:0]    grant_nxt;
   logic                  busy_nxt, rsp_valid_nxt, chip_sel_nxt, read_ena_nxt;
   logic [ID_WIDTH-1:0]   rsp_id_nxt;
   logic [WIDTH-1:0]      rsp_data_nxt;
   logic [ADDR_WIDTH-1:0] address_nxt;

   logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
   logic [ID_WIDTH-1:0]   winner, idx;
   logic                  found;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Search starts just past the previous winner and wraps.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      grant_nxt     = '0;
      busy_nxt      = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_id_nxt    = rsp_id;
      rsp_data_nxt  = rsp_data;
      chip_sel_nxt  = 1'b0;
      read_ena_nxt  = 1'b0;
      address_nxt   = rom_address;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt         = ISSUE;
               rr_ptr_nxt        = winner;
               grant_nxt[winner] = 1'b1;
               chip_sel_nxt      = 1'b1;
               read_ena_nxt      = 1'b1;
               address_nxt       = addr_arr[winner];
               busy_nxt          = 1'b1;
            end
         end
         ISSUE: begin
            state_nxt = CAPTURE;
            busy_nxt  = 1'b1;
         end
         CAPTURE: begin
            state_nxt     = IDLE;
            rsp_valid_nxt = 1'b1;
            rsp_id_nxt    = rr_ptr;
            rsp_data_nxt  = rom_data_in;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         rr_ptr       <= ID_WIDTH'(NUM_REQ - 1);
         grant        <= '0;
         busy         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_data     <= '0;
         rom_chip_sel <= 1'b0;
         rom_read_ena <= 1'b0;
         rom_address  <= '0;
      end else begin
         state        <= state_nxt;
         rr_ptr       <= rr_ptr_nxt;
         grant        <= grant_nxt;
         busy         <= busy_nxt;
         rsp_valid    <= rsp_valid_nxt;
         rsp_id       <= rsp_id_nxt;
         rsp_data     <= rsp_data_nxt;
         rom_chip_sel <= chip_sel_nxt;
         rom_read_ena <= read_ena_nxt;
         rom_address  <= address_nxt;
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: ROM holds 1<<addr; a transaction-timeline model is checked every cycle.
module tb_rom_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int AW = 3;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]  grant;
   logic          busy, rsp_valid, rom_chip_sel, rom_read_ena;
   logic [IW-1:0] rsp_id;
   logic [W-1:0]  rsp_data;
   logic [AW-1:0] rom_address;
   logic [W-1:0]  rom_q = '0;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rom_chip_sel && rom_read_ena) rom_q <= 8'h01 << rom_address;

   rom_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(8)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
      .grant(grant), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rom_chip_sel(rom_chip_sel), .rom_read_ena(rom_read_ena),
      .rom_address(rom_address), .rom_data_in(rom_q)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (r[i[IW-1:0]]) return i;
      end
      return -1;
   endfunction

   // Model: a transaction accepted at negedge prediction step has its grant cycle
   // next; response arrives two cycles after the grant, when the arbiter is free again.
   logic [N-1:0]  m_grant;
   logic          m_busy, m_rv, m_cs, m_re;
   logic [IW-1:0] m_id;
   logic [W-1:0]  m_data;
   logic [AW-1:0] m_addr;
   int            m_last, m_age, m_cur, m_w;
   bit            m_ready = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (m_ready) begin
            chk("grant", grant, m_grant);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
            chk("rom_chip_sel", rom_chip_sel, m_cs);
            chk("rom_read_ena", rom_read_ena, m_re);
            chk("rom_address", rom_address, m_addr);
         end
         m_grant = '0; m_cs = 1'b0; m_re = 1'b0; m_rv = 1'b0; m_busy = 1'b0;
         if (reset !== 1'b1) begin
            m_id = '0; m_data = '0; m_addr = '0;
            m_last = N - 1; m_age = -1;
         end else begin
            if (m_age == 0) m_busy = 1'b1;
            if (m_age == 1) begin
               m_rv   = 1'b1;
               m_id   = IW'(m_cur);
               m_data = 8'h01 << m_addr;
            end
            m_w = (m_age < 0 || m_age >= 2) ? rr_pick(req, m_last) : -1;
            if (m_w >= 0) begin
               m_grant[m_w[IW-1:0]] = 1'b1;
               m_cs = 1'b1; m_re = 1'b1; m_busy = 1'b1;
               m_addr = req_addr[m_w*AW +: AW];
               m_last = m_w; m_cur = m_w; m_age = 0;
            end else if (m_age >= 0 && m_age < 2) begin
               m_age++;
            end
         end
         m_ready = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int w, output int at);
      w = -1; at = -1;
      for (int i = 0; i < 12 && at < 0; i++) begin
         tick();
         if (grant != '0) begin
            at = cyc;
            for (int k = 0; k < N; k++) if (grant[k]) w = k;
         end
      end
      chk("grant_seen", (at >= 0), 1);
   endtask

   task automatic wait_rsp(output int id, output logic [W-1:0] d, output int at);
      id = -1; d = '0; at = -1;
      for (int i = 0; i < 12 && at < 0; i++) begin
         tick();
         if (rsp_valid === 1'b1) begin
            at = cyc; id = rsp_id; d = rsp_data;
         end
      end
      chk("rsp_seen", (at >= 0), 1);
   endtask

   task automatic do_read(input string tag, input logic [N-1:0] mask,
                          input int exp_w, input logic [W-1:0] exp_d);
      int w, g, id, r;
      logic [W-1:0] d;
      req = mask;
      wait_grant(w, g);
      req = '0;
      chk({tag, "_winner"}, w, exp_w);
      wait_rsp(id, d, r);
      chk({tag, "_id"}, id, exp_w);
      chk({tag, "_data"}, d, exp_d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int w, g, prev, id, r;
      logic [W-1:0] d;
      int exp_order [5] = '{0, 1, 2, 3, 0};
      logic [W-1:0] exp_data [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};

      reset = 1'b0;
      req   = '1;
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
      repeat (3) begin
         @(negedge clk);
         chk("rst_grant", grant, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_chip_sel", rom_chip_sel, 0);
         chk("rst_busy", busy, 0);
      end

      // Single read by requester 2 from address 3.
      tick();
      reset = 1'b1;
      req   = 4'b0100;
      req_addr[2*AW +: AW] = 3'd3;
      wait_grant(w, g);
      req = '0;
      chk("single_grant", grant, 4'b0100);
      chk("single_cs", rom_chip_sel, 1);
      chk("single_re", rom_read_ena, 1);
      chk("single_addr", rom_address, 3);
      wait_rsp(id, d, r);
      chk("single_latency", r - g, 2);
      chk("single_id", id, 2);
      chk("single_data", d, 8'h08);

      // Requester 3 moves the pointer to 3 so a full sweep starts at 0.
      req_addr[3*AW +: AW] = 3'd5;
      do_read("r3", 4'b1000, 3, 8'h20);
      req_addr[2*AW +: AW] = 3'd2;
      req_addr[3*AW +: AW] = 3'd3;

      req  = 4'b1111;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(w, g);
         if (k == 4) req = '0;
         chk("rr_winner", w, exp_order[k]);
         if (k > 0) chk("rr_spacing", g - prev, 3);
         prev = g;
         wait_rsp(id, d, r);
         chk("rr_data", d, exp_data[k]);
      end

      do_read("prio_a", 4'b0010, 1, 8'h02);
      do_read("prio_b", 4'b0011, 0, 8'h01);
      do_read("prio_c", 4'b1000, 3, 8'h08);
      do_read("prio_d", 4'b1010, 1, 8'h02);

      req_addr[0*AW +: AW] = 3'd7;
      do_read("wrap", 4'b0001, 0, 8'h80);

      // Reset lands in the capture cycle; the read must vanish.
      req = 4'b0001;
      wait_grant(w, g);
      req = '0;
      tick();
      reset = 1'b0;
      tick();
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp_data", rsp_data, 0);
      reset = 1'b1;
      do_read("post_rst", 4'b1000, 3, 8'h08);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
